avst_pkt_arbiter: RTL and testbench
===================================

# avst_pkt_arbiter

Packet-granular round-robin arbiter that shares one 128-bit Avalon-ST datapath, such as the downstream width converter, between N_PORTS requester streams. Once a port wins with a start-of-packet beat, its grant stays locked until the matching end-of-packet beat is accepted, so packets are never interleaved. The output is fully registered through a 2-entry skid buffer and carries the winning port index alongside the payload.

## Interface
Parameters:
- N_PORTS, default 4: number of requester streams, 2..8.
- DATA_W, default 128: beat width.
- EMPTY_W, default 4: empty field width, equal to log2(DATA_W/8).
- CHAN_W, default 128: channel field width, passed through unmodified.
- IDX_W, derived as max(1, clog2(N_PORTS)): width of the port index.

Ports (per-port signals are flattened vectors; port i occupies slice i):
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- avst_in_valid, input, N_PORTS: per-port valid.
- avst_in_ready, output, N_PORTS: per-port ready; at most one bit is set.
- avst_in_startofpacket, input, N_PORTS: per-port start of packet.
- avst_in_endofpacket, input, N_PORTS: per-port end of packet.
- avst_in_data, input, N_PORTS*DATA_W: per-port data.
- avst_in_empty, input, N_PORTS*EMPTY_W: per-port empty.
- avst_in_channel, input, N_PORTS*CHAN_W: per-port channel.
- avst_out_ready, input, 1: downstream ready.
- avst_out_valid, output, 1: output valid.
- avst_out_startofpacket, output, 1: output start of packet.
- avst_out_endofpacket, output, 1: output end of packet.
- avst_out_data, output, DATA_W: output data.
- avst_out_empty, output, EMPTY_W: output empty.
- avst_out_channel, output, CHAN_W: output channel.
- avst_out_port, output, IDX_W: index of the source port of the current output beat.
- sop_err, output, 1: one-cycle pulse when a beat without start-of-packet is accepted in IDLE.

## Operation
- A beat transfers on any interface when valid and ready are both high in the same cycle.
- State machine with two states, IDLE and LOCKED, plus registers lock_idx and last_idx.
- IDLE:
  - Combinational round-robin pick among ports with valid=1, scanning from last_idx+1 and wrapping modulo N_PORTS.
  - avst_in_ready[pick] = skid_has_space. All other ready bits are 0.
- On an accepted beat in IDLE:
  - last_idx <= pick.
  - If eop=0: go to LOCKED and set lock_idx <= pick.
  - If eop=1 (single-beat packet): stay in IDLE.
  - If sop=0: the beat is still forwarded and sop_err pulses for one cycle. Error beats are never dropped.
- LOCKED:
  - avst_in_ready[lock_idx] = skid_has_space. All other ready bits are 0.
  - Valid on other ports is ignored and their beats stay held upstream.
  - An accepted beat with eop=1 returns the block to IDLE. The next arbitration starts in the following cycle, so there is a one-cycle arbitration slot between packets.
  - sop=1 mid-packet is forwarded unchanged. No error is flagged.
- Payload fields (sop, eop, data, empty, channel) and the source index are written into the skid buffer unmodified. No width or empty arithmetic is performed.
- Reset (rst=1 at a clock edge):
  - state <= IDLE; lock_idx <= 0; last_idx <= N_PORTS-1, so port 0 has first priority.
  - Skid buffer is emptied.
  - avst_out_valid, avst_out_startofpacket, avst_out_endofpacket, sop_err <= 0; avst_out_data, avst_out_empty, avst_out_channel, avst_out_port <= 0.
  - avst_in_ready is forced to all-zero while rst=1.
- Reset mid-packet abandons the lock. After reset the arbiter starts fresh in IDLE, and the downstream consumer sees a truncated packet, which is acceptable.

## Timing
- Input-to-output latency is 1 cycle: a beat accepted in cycle t appears on avst_out_* in cycle t+1.
- skid_has_space is a registered signal (fewer than 2 entries occupied, or entry 0 leaving). avst_in_ready therefore never depends combinationally on avst_out_ready.
- With avst_out_ready held high, throughput is 1 beat per cycle within a packet. Back-to-back packets from any ports cost one idle input cycle between them.
- When avst_out_ready drops, at most one further beat is absorbed into the second skid entry. After that, input ready is 0 until an entry drains.
- avst_out_* is stable while avst_out_valid=1 and avst_out_ready=0.

## Structure
- Shared package avst_pkg holds:
  - the beat record typedef avst_beat_t (sop, eop, data, empty, channel);
  - the state enum arb_state_e {IDLE, LOCKED};
  - the width constants.
- One sub-module, avst_skid_buf: a generic 2-entry registered skid buffer carrying avst_beat_t plus the port index. It is reusable on other AvST paths.

## Test plan
1. Round-robin order: ports 0..3 each present one 3-beat packet in the same cycle after reset. Output order must be ports 0, 1, 2, 3, with avst_out_port matching and 12 output beats plus 3 inter-packet bubbles.
2. Lock hold: port 2 starts a 4-beat packet, and port 0 raises valid at beat 2. Port 0 must see ready=0 until port 2's eop is accepted, and port 0's sop must appear immediately after port 2's eop on the output.
3. Backpressure: hold avst_out_ready=0 for 5 cycles mid-packet. Exactly 2 beats are buffered, avst_out_* stays constant, and no beat is lost or duplicated after release.
4. Single-beat packets: ports 1 and 3 repeatedly send sop=eop=1. Output must alternate 1, 3, 1, 3, and the state never leaves IDLE.
5. Protocol error: port 0 sends a beat with sop=0 in IDLE. The beat is forwarded, and sop_err=1 for exactly 1 cycle.
6. Reset mid-packet: assert rst for 1 cycle during beat 2 of a port 1 packet. The next cycle shows avst_out_valid=0 and avst_in_ready=0. After reset, port 0 wins first when ports 0 and 1 are both valid.

Source files
------------

// File: rtl/avst_pkg.sv
// Shared Avalon-ST definitions: default widths, beat record and arbiter state encoding.
package avst_pkg;

  localparam int AVST_DATA_W  = 128;
  localparam int AVST_EMPTY_W = 4;
  localparam int AVST_CHAN_W  = 128;

  typedef struct packed {
    logic                    sop;
    logic                    eop;
    logic [AVST_DATA_W-1:0]  data;
    logic [AVST_EMPTY_W-1:0] empty;
    logic [AVST_CHAN_W-1:0]  channel;
  } avst_beat_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/avst_skid_buf.sv
// Generic 2-entry registered skid buffer for an Avalon-ST beat plus a side index.
// space_o is registered, so the upstream ready never sees out_ready_i combinationally.
module avst_skid_buf
  import avst_pkg::*;
#(
  parameter type beat_t = avst_beat_t,
  parameter int  IDX_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  beat_t            in_beat_i,
  input  logic [IDX_W-1:0] in_idx_i,
  output logic             space_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output beat_t            out_beat_o,
  output logic [IDX_W-1:0] out_idx_o
);

  beat_t            beat0_q, beat0_d, beat1_q, beat1_d;
  logic [IDX_W-1:0] idx0_q, idx0_d, idx1_q, idx1_d;
  logic [1:0]       count_q, count_d;
  logic             space_q;
  logic             pop;

  assign pop = (count_q != 2'd0) && out_ready_i;

  always_comb begin
    beat0_d = beat0_q;
    beat1_d = beat1_q;
    idx0_d  = idx0_q;
    idx1_d  = idx1_q;
    if (pop && (count_q == 2'd2)) begin
      beat0_d = beat1_q;
      idx0_d  = idx1_q;
    end
    // Entry 0 always holds the oldest beat; a new beat lands in entry 1 only when entry 0 stays.
    if (push_i) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        beat0_d = in_beat_i;
        idx0_d  = in_idx_i;
      end else begin
        beat1_d = in_beat_i;
        idx1_d  = in_idx_i;
      end
    end
    count_d = count_q + {1'b0, push_i} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat0_q <= '0;
      beat1_q <= '0;
      idx0_q  <= '0;
      idx1_q  <= '0;
      count_q <= 2'd0;
      space_q <= 1'b0;
    end else begin
      beat0_q <= beat0_d;
      beat1_q <= beat1_d;
      idx0_q  <= idx0_d;
      idx1_q  <= idx1_d;
      count_q <= count_d;
      space_q <= (count_d != 2'd2);
    end
  end

  assign space_o     = space_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_beat_o  = beat0_q;
  assign out_idx_o   = idx0_q;

endmodule

// File: rtl/avst_pkt_arbiter.sv
// Packet-granular round-robin arbiter: N Avalon-ST requesters share one registered output,
// with the grant held from a winning beat until its end-of-packet is accepted.
module avst_pkt_arbiter
  import avst_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = AVST_DATA_W,
  parameter int EMPTY_W = AVST_EMPTY_W,
  parameter int CHAN_W  = AVST_CHAN_W,
  parameter int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_PORTS-1:0]     avst_in_valid,
  output logic [N_PORTS-1:0]     avst_in_ready,
  input  logic [N_PORTS-1:0]     avst_in_startofpacket,
  input  logic [N_PORTS-1:0]     avst_in_endofpacket,
  input  logic [N_PORTS*DATA_W-1:0]  avst_in_data,
  input  logic [N_PORTS*EMPTY_W-1:0] avst_in_empty,
  input  logic [N_PORTS*CHAN_W-1:0]  avst_in_channel,
  input  logic                   avst_out_ready,
  output logic                   avst_out_valid,
  output logic                   avst_out_startofpacket,
  output logic                   avst_out_endofpacket,
  output logic [DATA_W-1:0]      avst_out_data,
  output logic [EMPTY_W-1:0]     avst_out_empty,
  output logic [CHAN_W-1:0]      avst_out_channel,
  output logic [IDX_W-1:0]       avst_out_port,
  output logic                   sop_err
);

  // Same layout as avst_beat_t, but sized by this instance's parameters.
  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [DATA_W-1:0]  data;
    logic [EMPTY_W-1:0] empty;
    logic [CHAN_W-1:0]  channel;
  } arb_beat_t;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d, last_idx_q, last_idx_d;
  logic [IDX_W-1:0] pick_idx, cand_idx, sel_idx;
  logic             pick_valid, grant_en, push, space;
  logic             gap_q, sop_err_q;
  arb_beat_t        port_beat [N_PORTS];
  arb_beat_t        sel_beat, out_beat;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign port_beat[gi] = {avst_in_startofpacket[gi], avst_in_endofpacket[gi],
                            avst_in_data[gi*DATA_W +: DATA_W],
                            avst_in_empty[gi*EMPTY_W +: EMPTY_W],
                            avst_in_channel[gi*CHAN_W +: CHAN_W]};
    assign avst_in_ready[gi] = grant_en && (sel_idx == IDX_W'(gi));
  end

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand_idx = IDX_W'((int'(last_idx_q) + k) % N_PORTS);
      if (!pick_valid && avst_in_valid[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // The cycle after any accepted eop grants nothing: that is the inter-packet arbitration slot.
  assign sel_idx  = (state_q == LOCKED) ? lock_idx_q : pick_idx;
  assign grant_en = !rst && space && !gap_q && ((state_q == LOCKED) || pick_valid);
  assign sel_beat = port_beat[sel_idx];
  assign push     = grant_en && avst_in_valid[sel_idx];

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    last_idx_d = last_idx_q;
    if (push) begin
      last_idx_d = sel_idx;
      if (state_q == IDLE) begin
        if (!sel_beat.eop) begin
          state_d    = LOCKED;
          lock_idx_d = sel_idx;
        end
      end else if (sel_beat.eop) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      last_idx_q <= IDX_W'(N_PORTS - 1);
      gap_q      <= 1'b0;
      sop_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      last_idx_q <= last_idx_d;
      gap_q      <= push && sel_beat.eop;
      sop_err_q  <= push && (state_q == IDLE) && !sel_beat.sop;
    end
  end

  avst_skid_buf #(
    .beat_t (arb_beat_t),
    .IDX_W  (IDX_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .in_beat_i   (sel_beat),
    .in_idx_i    (sel_idx),
    .space_o     (space),
    .out_valid_o (avst_out_valid),
    .out_ready_i (avst_out_ready),
    .out_beat_o  (out_beat),
    .out_idx_o   (avst_out_port)
  );

  assign avst_out_startofpacket = out_beat.sop;
  assign avst_out_endofpacket   = out_beat.eop;
  assign avst_out_data          = out_beat.data;
  assign avst_out_empty         = out_beat.empty;
  assign avst_out_channel       = out_beat.channel;
  assign sop_err                = sop_err_q;

endmodule

// File: tb/tb_avst_pkt_arbiter.sv
// Directed bench for avst_pkt_arbiter: per-port beat sources, an output log, and
// hand-derived expectations for ordering, locking, backpressure, errors and reset.
module tb_avst_pkt_arbiter;
  import avst_pkg::*;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int EW = 4;
  localparam int CW = 128;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    avst_in_valid, avst_in_ready, avst_in_startofpacket, avst_in_endofpacket;
  logic [N*DW-1:0] avst_in_data;
  logic [N*EW-1:0] avst_in_empty;
  logic [N*CW-1:0] avst_in_channel;
  logic            avst_out_ready, avst_out_valid, avst_out_startofpacket, avst_out_endofpacket;
  logic [DW-1:0]   avst_out_data;
  logic [EW-1:0]   avst_out_empty;
  logic [CW-1:0]   avst_out_channel;
  logic [IW-1:0]   avst_out_port;
  logic            sop_err;

  always #5 clk = ~clk;

  avst_pkt_arbiter #(.N_PORTS(N), .DATA_W(DW), .EMPTY_W(EW), .CHAN_W(CW)) dut (
    .clk(clk), .rst(rst),
    .avst_in_valid(avst_in_valid), .avst_in_ready(avst_in_ready),
    .avst_in_startofpacket(avst_in_startofpacket), .avst_in_endofpacket(avst_in_endofpacket),
    .avst_in_data(avst_in_data), .avst_in_empty(avst_in_empty), .avst_in_channel(avst_in_channel),
    .avst_out_ready(avst_out_ready), .avst_out_valid(avst_out_valid),
    .avst_out_startofpacket(avst_out_startofpacket), .avst_out_endofpacket(avst_out_endofpacket),
    .avst_out_data(avst_out_data), .avst_out_empty(avst_out_empty),
    .avst_out_channel(avst_out_channel), .avst_out_port(avst_out_port), .sop_err(sop_err)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-port source FIFOs: {sop, eop, tag}; tag = {port, packet id, beat number}.
  logic [17:0]  smem [N][16];
  int           head [N] = '{default: 0};
  int           tail [N] = '{default: 0};
  logic [N-1:0] acc = '0;

  always @(negedge clk) acc = avst_in_valid & avst_in_ready;

  always @(posedge clk) begin
    #1;
    for (int p = 0; p < N; p++) begin
      logic [17:0] b;
      if (acc[p]) head[p]++;
      b = smem[p][head[p] % 16];
      avst_in_valid[p]           = (head[p] != tail[p]);
      avst_in_startofpacket[p]   = b[17];
      avst_in_endofpacket[p]     = b[16];
      avst_in_data[p*DW +: DW]   = {8{b[15:0]}};
      avst_in_empty[p*EW +: EW]  = b[3:0];
      avst_in_channel[p*CW +: CW] = {8{~b[15:0]}};
    end
  end

  // Output log: {port, sop, eop, tag} and the cycle each beat left.
  logic [25:0] olog [64];
  int          ocyc [64];
  int          on = 0;

  always @(negedge clk) begin
    if (avst_out_valid && avst_out_ready) begin
      logic [15:0] t;
      t = avst_out_data[15:0];
      nvec++;
      assert (avst_out_data === {8{t}} && avst_out_channel === {8{~t}} && avst_out_empty === t[3:0])
      else begin
        nerr++;
        $error("FAIL out_payload: observed data %0h empty %0h expected tag %0h", avst_out_data[31:0], avst_out_empty, t);
      end
      if (on < 64) begin
        olog[on] = {8'(avst_out_port), avst_out_startofpacket, avst_out_endofpacket, t};
        ocyc[on] = cyc;
        on++;
      end
    end
  end

  function automatic logic [25:0] rec(int port, bit sop, bit eop, int pkt, int beat);
    return {8'(port), sop, eop, 4'(port), 4'(pkt), 8'(beat)};
  endfunction

  task automatic send(int p, int pkt, int n, bit first_sop = 1'b1);
    for (int b = 0; b < n; b++) begin
      smem[p][tail[p] % 16] = {(b == 0) && first_sop, b == n - 1, 4'(p), 4'(pkt), 8'(b)};
      tail[p]++;
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int locked_cnt, err_cnt, err_cyc;

  initial begin
    rst = 1'b1;
    avst_out_ready = 1'b1;
    avst_in_valid = '0; avst_in_startofpacket = '0; avst_in_endofpacket = '0;
    avst_in_data = '0; avst_in_empty = '0; avst_in_channel = '0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", avst_in_ready, 0);
    @(negedge clk);
    chk("rst_out_valid", avst_out_valid, 0);
    chk("rst_out_data", avst_out_data[63:0], 0);
    chk("rst_out_port", avst_out_port, 0);
    chk("rst_sop_err", sop_err, 0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: round-robin order 0,1,2,3 with one bubble between packets
    on = 0;
    for (int p = 0; p < N; p++) send(p, 1, 3);
    repeat (20) @(negedge clk);
    chk("t1_beats", on, 12);
    for (int i = 0; i < 12; i++) chk("t1_order", olog[i], rec(i / 3, i % 3 == 0, i % 3 == 2, 1, i % 3));
    chk("t1_span", ocyc[11] - ocyc[0], 14);

    // 2: port 2 holds the grant while port 0 waits
    on = 0;
    send(2, 2, 4);
    @(negedge clk);
    send(0, 3, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_locked_ready", avst_in_ready, 4'b0100);
    end
    @(negedge clk);
    chk("t2_gap_ready", avst_in_ready, 4'b0000);
    @(negedge clk);
    chk("t2_p0_ready", avst_in_ready, 4'b0001);
    repeat (4) @(negedge clk);
    chk("t2_beats", on, 6);
    for (int i = 0; i < 4; i++) chk("t2_p2", olog[i], rec(2, i == 0, i == 3, 2, i));
    chk("t2_p0_sop", olog[4], rec(0, 1, 0, 3, 0));
    chk("t2_p0_eop", olog[5], rec(0, 0, 1, 3, 1));

    // 4: single-beat packets alternate 1,3 without leaving IDLE
    on = 0;
    for (int k = 4; k < 7; k++) begin
      send(1, k, 1);
      send(3, k, 1);
    end
    locked_cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (dut.state_q !== IDLE) locked_cnt++;
    end
    chk("t4_never_locked", locked_cnt, 0);
    chk("t4_beats", on, 6);
    for (int i = 0; i < 6; i++) chk("t4_order", olog[i], rec((i % 2 == 1) ? 3 : 1, 1, 1, 4 + i / 2, 0));

    // 3: backpressure for 5 cycles mid-packet
    on = 0;
    send(1, 7, 6);
    @(posedge clk);
    @(posedge clk); #2 avst_out_ready = 1'b0;
    @(negedge clk);
    chk("t3_absorb_ready", avst_in_ready, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", avst_out_valid, 1);
      chk("t3_hold_data", avst_out_data[15:0], 16'h1700);
      chk("t3_hold_ready", avst_in_ready, 4'b0000);
    end
    chk("t3_buffered", tail[1] - head[1], 4);
    @(posedge clk); #2 avst_out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t3_beats", on, 6);
    for (int i = 0; i < 6; i++) chk("t3_order", olog[i], rec(1, i == 0, i == 5, 7, i));

    // 5: beat without sop in IDLE is forwarded and flagged once
    on = 0;
    err_cnt = 0;
    err_cyc = -1;
    send(0, 8, 1, 1'b0);
    repeat (6) begin
      @(negedge clk);
      if (sop_err === 1'b1) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
    chk("t5_err_pulses", err_cnt, 1);
    chk("t5_beats", on, 1);
    chk("t5_beat", olog[0], rec(0, 0, 1, 8, 0));
    chk("t5_err_align", err_cyc, ocyc[0]);

    // 6: reset during beat 2 of a port 1 packet
    on = 0;
    send(1, 9, 4);
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("t6_ready_in_rst", avst_in_ready, 4'b0000);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", avst_out_valid, 0);
    chk("t6_ready_after", avst_in_ready, 4'b0000);
    chk("t6_out_data", avst_out_data[63:0], 0);
    head[1] = tail[1];
    on = 0;
    send(0, 10, 1);
    send(1, 10, 1);
    @(negedge clk);
    chk("t6_p0_first", avst_in_ready, 4'b0001);
    repeat (6) @(negedge clk);
    chk("t6_beats", on, 2);
    chk("t6_first", olog[0], rec(0, 1, 1, 10, 0));
    chk("t6_second", olog[1], rec(1, 1, 1, 10, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
